// File: rtl/logic_op_pipeline.sv
// ---------------------------------------------------------------------------
// logic_op_pipeline
//   Bitwise logic unit (AND / OR / XOR / XNOR) on two WIDTH-bit operands with
//   three result views:
//     y_comb  - combinational op(a,b) of the live inputs
//     y_pipe  - STAGES-deep valid/ready pipelined result (global stall)
//     y_hold  - per-bit hold register, bit i loads b[i] where a[i]=1 on accept
//   plus a saturating count of output transfers.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  producer handshake for a/b/op
//   a, b, op           operands and operation (00 AND, 01 OR, 10 XOR, 11 XNOR)
//   y_comb             combinational result
//   out_valid/out_ready consumer handshake for y_pipe
//   y_pipe             pipelined result
//   y_hold             hold register
//   xfer_count         saturating output-transfer count
// ---------------------------------------------------------------------------

// One bit lane: combinational op plus its hold bit.
module logic_op_lane (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_i,
   input  logic       b_i,
   input  logic [1:0] op_i,
   input  logic       acc_i,
   output logic       y_o,
   output logic       hold_o
);
   logic hold_q, hold_d;

   always_comb begin
      y_o = 1'b0;
      case (op_i)
         2'b00:   y_o = a_i & b_i;
         2'b01:   y_o = a_i | b_i;
         2'b10:   y_o = a_i ^ b_i;
         default: y_o = ~(a_i ^ b_i);
      endcase
   end

   // a doubles as the per-bit load enable; b supplies the data.
   always_comb begin
      hold_d = hold_q;
      if (acc_i && a_i) hold_d = b_i;
   end

   always_ff @(posedge clk) begin
      if (rst) hold_q <= 1'b0;
      else     hold_q <= hold_d;
   end

   assign hold_o = hold_q;
endmodule

module logic_op_pipeline #(
   parameter int WIDTH   = 8,
   parameter int STAGES  = 2,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         op,
   output logic [WIDTH-1:0]   y_comb,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   y_pipe,
   output logic [WIDTH-1:0]   y_hold,
   output logic [COUNT_W-1:0] xfer_count
);

   generate
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("logic_op_pipeline: STAGES must be 1..4");
      end
   endgenerate

   logic advance, accept, xfer;

   // Whole pipeline moves as one; an empty output slot or a taking consumer
   // lets every stage shift, bubbles included.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign accept   = in_valid && advance;
   assign xfer     = out_valid && out_ready;

   // Per-bit lanes
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_lane
         logic_op_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .a_i    (a[gi]),
            .b_i    (b[gi]),
            .op_i   (op),
            .acc_i  (accept),
            .y_o    (y_comb[gi]),
            .hold_o (y_hold[gi])
         );
      end
   endgenerate

   // Pipeline: stage 1 is fed from the input, stage STAGES drives the output.
   logic [STAGES:1]            vld_pipe_q, vld_pipe_d;
   logic [STAGES:1][WIDTH-1:0] dat_pipe_q, dat_pipe_d;

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      dat_pipe_d = dat_pipe_q;
      if (advance) begin
         vld_pipe_d[1] = in_valid;
         dat_pipe_d[1] = y_comb;
         for (int s = 2; s <= STAGES; s++) begin
            vld_pipe_d[s] = vld_pipe_q[s-1];
            dat_pipe_d[s] = dat_pipe_q[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         dat_pipe_q <= dat_pipe_d;
      end
   end

   assign out_valid = vld_pipe_q[STAGES];
   assign y_pipe    = dat_pipe_q[STAGES];

   // Saturating transfer counter; holds at all-ones instead of wrapping.
   logic [COUNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (xfer && (cnt_q != {COUNT_W{1'b1}})) cnt_d = cnt_q + COUNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign xfer_count = cnt_q;

endmodule

// File: tb/tb_logic_op_pipeline.sv
module tb_logic_op_pipeline;
   logic       clk, rst, in_valid, out_ready;
   logic [7:0] a, b;
   logic [1:0] op;

   logic        m_in_ready, m_out_valid;
   logic [7:0]  m_y_comb, m_y_pipe, m_y_hold;
   logic [15:0] m_xfer_count;
   logic        c_in_ready, c_out_valid;
   logic [7:0]  c_y_comb, c_y_pipe, c_y_hold;
   logic [3:0]  c_xfer_count;
   logic        s1_in_ready, s1_out_valid;
   logic [7:0]  s1_y_comb, s1_y_pipe, s1_y_hold;
   logic [15:0] s1_xfer_count;
   logic        s4_in_ready, s4_out_valid;
   logic [7:0]  s4_y_comb, s4_y_pipe, s4_y_hold;
   logic [15:0] s4_xfer_count;

   int n_chk = 0;
   int n_pass = 0;

   logic_op_pipeline #(.WIDTH(8), .STAGES(2), .COUNT_W(16)) u_m (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .a(a), .b(b), .op(op),
      .y_comb(m_y_comb), .out_valid(m_out_valid), .out_ready(out_ready), .y_pipe(m_y_pipe),
      .y_hold(m_y_hold), .xfer_count(m_xfer_count));
   logic_op_pipeline #(.WIDTH(8), .STAGES(2), .COUNT_W(4)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .a(a), .b(b), .op(op),
      .y_comb(c_y_comb), .out_valid(c_out_valid), .out_ready(out_ready), .y_pipe(c_y_pipe),
      .y_hold(c_y_hold), .xfer_count(c_xfer_count));
   logic_op_pipeline #(.WIDTH(8), .STAGES(1), .COUNT_W(16)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready), .a(a), .b(b), .op(op),
      .y_comb(s1_y_comb), .out_valid(s1_out_valid), .out_ready(out_ready), .y_pipe(s1_y_pipe),
      .y_hold(s1_y_hold), .xfer_count(s1_xfer_count));
   logic_op_pipeline #(.WIDTH(8), .STAGES(4), .COUNT_W(16)) u_s4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s4_in_ready), .a(a), .b(b), .op(op),
      .y_comb(s4_y_comb), .out_valid(s4_out_valid), .out_ready(out_ready), .y_pipe(s4_y_pipe),
      .y_hold(s4_y_hold), .xfer_count(s4_xfer_count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain bitwise operators selected by op.
   function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
      case (o)
         2'b00:   return x & y;
         2'b01:   return x | y;
         2'b10:   return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      step; step;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'hFF; b = 8'hFF; op = '0;
      step; step;
      n_chk++; if (m_out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", m_out_valid); else n_pass++;
      n_chk++; if (m_y_pipe !== 8'h00) $display("FAIL rst_y_pipe got %h exp 00", m_y_pipe); else n_pass++;
      n_chk++; if (m_y_hold !== 8'h00) $display("FAIL rst_y_hold got %h exp 00", m_y_hold); else n_pass++;
      n_chk++; if (m_xfer_count !== 16'd0) $display("FAIL rst_xfer got %0d exp 0", m_xfer_count); else n_pass++;
      n_chk++; if (c_xfer_count !== 4'd0 || s1_out_valid !== 1'b0 || s4_out_valid !== 1'b0)
         $display("FAIL rst_other got c=%0d s1v=%b s4v=%b exp 0/0/0", c_xfer_count, s1_out_valid, s4_out_valid); else n_pass++;
      rst = 1'b0;
      #1;
      n_chk++; if (m_in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", m_in_ready); else n_pass++;
   endtask

   task automatic test_ops;
      logic [7:0] exp_tab [4] = '{8'hA0, 8'hFA, 8'h5A, 8'hA5};
      do_reset;
      for (int o = 0; o < 4; o++) begin
         in_valid = 1'b1; a = 8'hF0; b = 8'hAA; op = 2'(o); out_ready = 1'b1;
         #1;
         n_chk++; if (m_y_comb !== exp_tab[o]) $display("FAIL ops_comb op=%0d got %h exp %h", o, m_y_comb, exp_tab[o]); else n_pass++;
         n_chk++; if (s4_y_comb !== exp_tab[o]) $display("FAIL ops_comb_s4 op=%0d got %h exp %h", o, s4_y_comb, exp_tab[o]); else n_pass++;
         n_chk++; if (m_in_ready !== 1'b1) $display("FAIL ops_in_ready op=%0d got %b exp 1", o, m_in_ready); else n_pass++;
         step;
         in_valid = 1'b0; a = 8'h00; b = 8'h00;
         n_chk++; if (m_out_valid !== 1'b0) $display("FAIL ops_early op=%0d got %b exp 0", o, m_out_valid); else n_pass++;
         step;
         n_chk++; if (m_out_valid !== 1'b1) $display("FAIL ops_valid op=%0d got %b exp 1", o, m_out_valid); else n_pass++;
         n_chk++; if (m_y_pipe !== exp_tab[o]) $display("FAIL ops_pipe op=%0d got %h exp %h", o, m_y_pipe, exp_tab[o]); else n_pass++;
         step;
         n_chk++; if (m_out_valid !== 1'b0) $display("FAIL ops_once op=%0d got %b exp 0", o, m_out_valid); else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp_q [$];
      logic [7:0] e;
      int sent = 0, got = 0, stall_left = 3;
      bit stall_on = 0;
      do_reset;
      op = 2'b10; b = 8'h00;
      for (int c = 0; c < 40 && got < 4; c++) begin
         in_valid = (sent < 4);
         a = 8'(sent + 1);
         if (m_out_valid) stall_on = 1;
         out_ready = !(stall_on && stall_left > 0);
         #1;
         if (!out_ready) begin
            n_chk++; if (m_in_ready !== 1'b0) $display("FAIL b2b_stall_ready got %b exp 0", m_in_ready); else n_pass++;
            n_chk++; if (m_out_valid !== 1'b1 || m_y_pipe !== 8'h01)
               $display("FAIL b2b_stall_hold got v=%b y=%h exp v=1 y=01", m_out_valid, m_y_pipe); else n_pass++;
            stall_left--;
         end
         if (m_out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            n_chk++; if (m_y_pipe !== e) $display("FAIL b2b_order idx=%0d got %h exp %h", got, m_y_pipe, e); else n_pass++;
            got++;
         end
         if (in_valid && (!m_out_valid || out_ready)) begin
            exp_q.push_back(8'(sent + 1));
            sent++;
         end
         step;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_chk++; if (got !== 4) $display("FAIL b2b_count got %0d exp 4", got); else n_pass++;
      n_chk++; if (m_xfer_count !== 16'd4) $display("FAIL b2b_xfer got %0d exp 4", m_xfer_count); else n_pass++;
      step;
      n_chk++; if (m_out_valid !== 1'b0) $display("FAIL b2b_dup got %b exp 0", m_out_valid); else n_pass++;
   endtask

   task automatic test_hold;
      logic [7:0] ta [3] = '{8'h0F, 8'hF0, 8'h01};
      logic [7:0] tb [3] = '{8'hFF, 8'h00, 8'h00};
      logic [7:0] te [3] = '{8'h0F, 8'h0F, 8'h0E};
      do_reset;
      out_ready = 1'b1; op = 2'b00;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = ta[i]; b = tb[i];
         step;
         n_chk++; if (m_y_hold !== te[i]) $display("FAIL hold_seq%0d got %h exp %h", i, m_y_hold, te[i]); else n_pass++;
         n_chk++; if (s4_y_hold !== te[i]) $display("FAIL hold_seq_s4_%0d got %h exp %h", i, s4_y_hold, te[i]); else n_pass++;
      end
      in_valid = 1'b0; a = 8'hFF; b = 8'hFF;
      step;
      n_chk++; if (m_y_hold !== 8'h0E) $display("FAIL hold_novalid got %h exp 0E", m_y_hold); else n_pass++;
      step; step;
      out_ready = 1'b0; in_valid = 1'b1; a = 8'h00; b = 8'h00;
      step; step;
      n_chk++; if (m_out_valid !== 1'b1) $display("FAIL hold_fill got %b exp 1", m_out_valid); else n_pass++;
      a = 8'hFF; b = 8'hFF;
      #1;
      n_chk++; if (m_in_ready !== 1'b0) $display("FAIL hold_stall_ready got %b exp 0", m_in_ready); else n_pass++;
      step;
      n_chk++; if (m_y_hold !== 8'h0E) $display("FAIL hold_stalled got %h exp 0E", m_y_hold); else n_pass++;
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midflight;
      do_reset;
      out_ready = 1'b1; in_valid = 1'b1; a = 8'h33; b = 8'hFF; op = 2'b00;
      step;
      in_valid = 1'b0;
      step; step;
      n_chk++; if (m_xfer_count !== 16'd1) $display("FAIL mid_pre_xfer got %0d exp 1", m_xfer_count); else n_pass++;
      out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'hFF; op = 2'b01;
      step;
      a = 8'h22;
      step;
      in_valid = 1'b0; rst = 1'b1;
      step;
      rst = 1'b0;
      n_chk++; if (m_out_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", m_out_valid); else n_pass++;
      n_chk++; if (m_y_pipe !== 8'h00) $display("FAIL mid_pipe got %h exp 00", m_y_pipe); else n_pass++;
      n_chk++; if (m_y_hold !== 8'h00) $display("FAIL mid_hold got %h exp 00", m_y_hold); else n_pass++;
      n_chk++; if (m_xfer_count !== 16'd0) $display("FAIL mid_xfer got %0d exp 0", m_xfer_count); else n_pass++;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step;
         n_chk++; if (m_out_valid !== 1'b0) $display("FAIL mid_ghost c=%0d got %b exp 0", c, m_out_valid); else n_pass++;
      end
      in_valid = 1'b1; a = 8'h5A; b = 8'h00; op = 2'b10;
      step;
      in_valid = 1'b0;
      step;
      n_chk++; if (m_out_valid !== 1'b1 || m_y_pipe !== 8'h5A)
         $display("FAIL mid_resume got v=%b y=%h exp v=1 y=5A", m_out_valid, m_y_pipe); else n_pass++;
   endtask

   task automatic test_saturation;
      int cnt_m = 0, tr = 0;
      do_reset;
      out_ready = 1'b1; b = 8'h00; op = 2'b01;
      for (int c = 0; c < 26; c++) begin
         in_valid = 1'b1; a = 8'($urandom);
         #1;
         if (c_out_valid && out_ready) begin
            tr++;
            cnt_m = (cnt_m + 1 > 15) ? 15 : cnt_m + 1;
         end
         step;
         n_chk++; if (c_xfer_count !== 4'(cnt_m)) $display("FAIL sat_count c=%0d got %0d exp %0d", c, c_xfer_count, cnt_m); else n_pass++;
      end
      in_valid = 1'b0;
      n_chk++; if (tr < 20 || c_xfer_count !== 4'd15) $display("FAIL sat_final got %0d after %0d xfers exp 15", c_xfer_count, tr); else n_pass++;
   endtask

   task automatic test_depth;
      logic [7:0] beat [8];
      do_reset;
      out_ready = 1'b1; in_valid = 1'b1; a = 8'h5C; b = 8'h00; op = 2'b01;
      step;
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         n_chk++; if (s1_out_valid !== (k == 0)) $display("FAIL depth_s1 k=%0d got %b", k, s1_out_valid); else n_pass++;
         n_chk++; if (s4_out_valid !== (k == 3)) $display("FAIL depth_s4 k=%0d got %b", k, s4_out_valid); else n_pass++;
         if (k == 0) begin n_chk++; if (s1_y_pipe !== 8'h5C) $display("FAIL depth_s1_y got %h exp 5C", s1_y_pipe); else n_pass++; end
         if (k == 3) begin n_chk++; if (s4_y_pipe !== 8'h5C) $display("FAIL depth_s4_y got %h exp 5C", s4_y_pipe); else n_pass++; end
         step;
      end
      do_reset;
      out_ready = 1'b1; b = 8'h00; op = 2'b10;
      for (int i = 0; i < 8; i++) beat[i] = 8'(i * 17 + 3);
      for (int i = 0; i < 12; i++) begin
         in_valid = (i < 8); a = (i < 8) ? beat[i] : 8'h00;
         #1;
         n_chk++; if (s1_in_ready !== 1'b1 || s4_in_ready !== 1'b1)
            $display("FAIL thru_ready i=%0d got %b%b exp 11", i, s1_in_ready, s4_in_ready); else n_pass++;
         step;
         n_chk++; if (s1_out_valid !== (i < 8) || (i < 8 && s1_y_pipe !== beat[i]))
            $display("FAIL thru_s1 i=%0d got v=%b y=%h", i, s1_out_valid, s1_y_pipe); else n_pass++;
         n_chk++; if (s4_out_valid !== (i >= 3 && i < 11) || (i >= 3 && i < 11 && s4_y_pipe !== beat[(i >= 3) ? i - 3 : 0]))
            $display("FAIL thru_s4 i=%0d got v=%b y=%h", i, s4_out_valid, s4_y_pipe); else n_pass++;
      end
      n_chk++; if (s1_xfer_count !== 16'd8 || s4_xfer_count !== 16'd8)
         $display("FAIL thru_xfer got %0d/%0d exp 8/8", s1_xfer_count, s4_xfer_count); else n_pass++;
   endtask

   task automatic test_random;
      logic [7:0] q [$];
      logic [7:0] hold_m = '0, prev = '0, e;
      int cnt_m = 0;
      bit stall_prev = 0, acc;
      do_reset;
      for (int c = 0; c < 300; c++) begin
         in_valid = 1'($urandom_range(0, 1)); a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_chk++; if (m_y_comb !== ref_op(a, b, op)) $display("FAIL rnd_comb c=%0d got %h exp %h", c, m_y_comb, ref_op(a, b, op)); else n_pass++;
         n_chk++; if (m_in_ready !== (!m_out_valid || out_ready)) $display("FAIL rnd_ready c=%0d got %b", c, m_in_ready); else n_pass++;
         if (stall_prev) begin
            n_chk++; if (m_out_valid !== 1'b1 || m_y_pipe !== prev)
               $display("FAIL rnd_stable c=%0d got v=%b y=%h exp v=1 y=%h", c, m_out_valid, m_y_pipe, prev); else n_pass++;
         end
         if (m_out_valid && out_ready) begin
            e = (q.size() > 0) ? q.pop_front() : 8'hXX;
            n_chk++; if (m_y_pipe !== e) $display("FAIL rnd_order c=%0d got %h exp %h", c, m_y_pipe, e); else n_pass++;
            cnt_m++;
         end
         stall_prev = m_out_valid && !out_ready;
         prev = m_y_pipe;
         acc = in_valid && (!m_out_valid || out_ready);
         if (acc) begin
            q.push_back(ref_op(a, b, op));
            hold_m = (hold_m & ~a) | (a & b);
         end
         step;
         n_chk++; if (m_y_hold !== hold_m) $display("FAIL rnd_hold c=%0d got %h exp %h", c, m_y_hold, hold_m); else n_pass++;
         n_chk++; if (m_xfer_count !== 16'(cnt_m)) $display("FAIL rnd_xfer c=%0d got %0d exp %0d", c, m_xfer_count, cnt_m); else n_pass++;
         if (q.size() == 0) begin
            n_chk++; if (m_out_valid !== 1'b0) $display("FAIL rnd_empty c=%0d got %b exp 0", c, m_out_valid); else n_pass++;
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      test_reset;
      test_ops;
      test_back_to_back;
      test_hold;
      test_reset_midflight;
      test_saturation;
      test_depth;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/logic_op_pipeline.md
Name: logic_op_pipeline

Overview:
Parametrised, multi-bit successor of the team's single-bit comb/flop/latch logic cell. It computes a selectable bitwise operation on two WIDTH-bit operands and exposes three views of the result. The first is a combinational view of the live inputs. The second is a STAGES-deep valid/ready pipelined view. The third is a clock-enabled per-bit hold register that replaces the old level-sensitive latch. It sits between a producer and consumer that both use valid/ready streaming.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
STAGES, 2, pipeline depth in registers from input to y_pipe (legal 1..4)
COUNT_W, 16, width of the output-transfer counter (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  producer has a beat on a/b/op
in_ready  output  1  block accepts the beat this cycle
a  input  WIDTH  operand A; also the per-bit hold enable mask
b  input  WIDTH  operand B; also the hold data
op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 XNOR
y_comb  output  WIDTH  combinational op(a,b) of the current inputs
out_valid  output  1  y_pipe holds a valid result
out_ready  input  1  consumer takes y_pipe this cycle
y_pipe  output  WIDTH  pipelined result
y_hold  output  WIDTH  hold register
xfer_count  output  COUNT_W  saturating count of output transfers

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled only on the rising edge of clk. Reset takes priority over every other event in the same cycle.
- Reset values: all stage valids=0, out_valid=0, y_pipe=0, y_hold=0, xfer_count=0. in_ready=1 in the first cycle after reset. y_comb is combinational and has no reset.
- y_comb: op(a,b) of the current inputs, independent of in_valid and of stalls. Zero-cycle latency.
- Accept condition: in_valid && in_ready.
- Output transfer condition: out_valid && out_ready.
- Stall rule (global enable): advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=1, every stage shifts by one. Stage 0 loads {valid=in_valid, data=op(a,b)}, where op is sampled alongside its data.
  - When advance=0, all stages hold, including data.
  - Bubbles are not collapsed; an empty stage still costs one cycle.
- Latency: with out_ready held at 1, a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1. The beat is visible for exactly one cycle. Throughput is 1 beat/cycle.
- Data stability: y_pipe and out_valid must not change while out_valid=1 and out_ready=0.
- y_hold: updates only on the accept condition. For each bit i, y_hold[i] <= a[i] ? b[i] : y_hold[i].
  - No update when in_valid=0 or when stalled. op does not affect y_hold.
- xfer_count: increments by 1 on each output transfer and saturates at 2^COUNT_W-1. It never wraps.
- Simultaneous events: an accept and an output transfer in the same cycle are both honoured; the pipeline shifts once.
- Reset mid-operation: all in-flight beats are discarded without appearing on the output. y_hold and xfer_count clear. The output resumes only with beats accepted after reset is released.
- Illegal STAGES (<1 or >4): elaboration error.

Test Plan:
All scenarios use WIDTH=8, STAGES=2 unless noted.
- Op/comb/latency: out_ready=1, single beat a=0xF0, b=0xAA, op=00 -> y_comb=0xA0 in the same cycle, then y_pipe=0xA0 with out_valid=1 one cycle after the accept edge. Repeat with op=01/10/11 -> 0xFA, 0x5A, 0xA5.
- Back-to-back with back-pressure: 4 beats with op=10, b=0x00, a=0x01..0x04. out_ready=0 for 3 cycles once the first result is valid.
  - in_ready=0 during the stall.
  - y_pipe holds 0x01 throughout the stall.
  - After release, outputs appear as 0x01, 0x02, 0x03, 0x04 in order with none lost or duplicated. xfer_count=4.
- Hold register, three accepted beats in sequence:
  - from reset, a=0x0F, b=0xFF -> y_hold=0x0F
  - a=0xF0, b=0x00 -> y_hold=0x0F
  - a=0x01, b=0x00 -> y_hold=0x0E
  - A beat with in_valid=0 or presented while stalled leaves y_hold unchanged.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0, y_pipe=0x00, y_hold=0x00, xfer_count=0 after the edge. Neither beat is ever emitted.
- Counter saturation (COUNT_W=4): 20 output transfers -> xfer_count reaches 15 and stays at 15.
- Depth sweep (STAGES=1 and 4): latency from the accept edge to out_valid is 0 and 3 cycles respectively. Full throughput holds with out_ready=1.
